// File: rtl/fft_result_streamer_pkg.sv
// Shared constants and state encoding for the FFT result streamer and its helpers.
package fft_result_streamer_pkg;

  localparam int unsigned SfpExpW      = 4;
  localparam int unsigned SfpSigW      = 4;
  localparam int unsigned SfpFormatW   = 1 + SfpExpW + SfpSigW;
  localparam int unsigned FftMaxPoints = 32;
  localparam int unsigned FftIdxW      = 5;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

  // Position of the highest set bit; 0 for v <= 1.
  function automatic int unsigned floor_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// Valid/ready stream carrying one complex FFT bin per beat plus its index.
interface fft_result_streamer_if
  import fft_result_streamer_pkg::*;
#(
  parameter int unsigned FormatWidth = SfpFormatW,
  parameter int unsigned IdxW        = FftIdxW
) ();

  logic                   valid;
  logic                   ready;
  logic [FormatWidth-1:0] re;
  logic [FormatWidth-1:0] im;
  logic [IdxW-1:0]        index;
  logic                   last;

  modport master (output valid, re, im, index, last, input ready);
  modport slave  (input valid, re, im, index, last, output ready);

endinterface

// File: rtl/fft_result_streamer_bitrev_idx.sv
// Reverses the low log2len_i bits of cnt_i; bits above that range pass through.
module fft_result_streamer_bitrev_idx #(
  parameter int unsigned IdxW  = 5,
  parameter int unsigned Log2W = $clog2(IdxW + 1)
) (
  input  logic [IdxW-1:0]  cnt_i,
  input  logic [Log2W-1:0] log2len_i,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0]  full_rev;
  logic [IdxW-1:0]  mask;
  logic [Log2W-1:0] shamt;

  always_comb begin
    full_rev = '0;
    for (int i = 0; i < int'(IdxW); i++) begin
      full_rev[i] = cnt_i[int'(IdxW) - 1 - i];
    end
    // Reversing all IdxW bits puts the wanted field at the top; shift it back down.
    shamt = Log2W'(IdxW) - log2len_i;
    mask  = ~({IdxW{1'b1}} << log2len_i);
    idx_o = ((full_rev >> shamt) & mask) | (cnt_i & ~mask);
  end

endmodule

// File: rtl/fft_result_streamer.sv
// Snapshots the FFT output buses on fft_done rising and replays the frame as a
// valid/ready stream, one complex bin per beat, in natural or bit-reversed order.
module fft_result_streamer
  import fft_result_streamer_pkg::*;
#(
  parameter int unsigned FormatWidth = SfpFormatW,
  parameter int unsigned NPoint      = FftMaxPoints,
  parameter int unsigned IdxW        = FftIdxW,
  parameter bit          BitRev      = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [10:0]                   fft_size_i,
  input  logic                          fft_done_i,
  input  logic [NPoint*FormatWidth-1:0] output_real_i,
  input  logic [NPoint*FormatWidth-1:0] output_imag_i,
  fft_result_streamer_if.master         m_if,
  output logic                          busy_o,
  output logic                          overrun_o
);

  localparam int unsigned LenW  = IdxW + 1;
  localparam int unsigned Log2W = $clog2(IdxW + 1);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        cnt_q, cnt_d;
  logic [LenW-1:0]        len_q, len_d;
  logic [Log2W-1:0]       log2len_q, log2len_d;
  logic                   fft_done_q;
  logic                   overrun_q, overrun_d;
  logic [FormatWidth-1:0] re_out_q, re_out_d;
  logic [FormatWidth-1:0] im_out_q, im_out_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   last_q, last_d;

  logic [FormatWidth-1:0] re_buf_q [NPoint];
  logic [FormatWidth-1:0] im_buf_q [NPoint];

  logic            done_rise;
  logic [LenW-1:0] len_in;
  logic            capture;
  logic [IdxW-1:0] cnt_nxt;
  logic [IdxW-1:0] k_rev;
  logic [IdxW-1:0] k_nxt;

  assign done_rise = fft_done_i & ~fft_done_q;
  assign len_in    = (fft_size_i > 11'(NPoint)) ? LenW'(NPoint) : fft_size_i[IdxW:0];
  assign capture   = (state_q == StIdle) & done_rise & (len_in >= LenW'(2));
  assign cnt_nxt   = cnt_q + IdxW'(1);
  assign k_nxt     = BitRev ? k_rev : cnt_nxt;

  fft_result_streamer_bitrev_idx #(
    .IdxW  (IdxW),
    .Log2W (Log2W)
  ) u_bitrev (
    .cnt_i     (cnt_nxt),
    .log2len_i (log2len_q),
    .idx_o     (k_rev)
  );

  // Frame buffer has no reset: contents are only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < int'(NPoint); k++) begin
        re_buf_q[k] <= output_real_i[k*FormatWidth +: FormatWidth];
        im_buf_q[k] <= output_imag_i[k*FormatWidth +: FormatWidth];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    log2len_d = log2len_q;
    re_out_d  = re_out_q;
    im_out_d  = im_out_q;
    idx_d     = idx_q;
    last_d    = last_q;
    overrun_d = overrun_q | (done_rise & (state_q == StStream));
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d   = StStream;
          cnt_d     = '0;
          len_d     = len_in;
          log2len_d = Log2W'(floor_log2(32'(len_in)));
          // Bin 0 is first in either order, so the first beat comes straight off the bus.
          re_out_d  = output_real_i[FormatWidth-1:0];
          im_out_d  = output_imag_i[FormatWidth-1:0];
          idx_d     = '0;
          last_d    = 1'b0;
        end
      end
      StStream: begin
        if (m_if.ready) begin
          if (last_q) begin
            state_d = StIdle;
            last_d  = 1'b0;
          end else begin
            cnt_d    = cnt_nxt;
            re_out_d = re_buf_q[k_nxt];
            im_out_d = im_buf_q[k_nxt];
            idx_d    = k_nxt;
            last_d   = ({1'b0, cnt_nxt} == (len_q - LenW'(1)));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      log2len_q  <= '0;
      fft_done_q <= 1'b0;
      overrun_q  <= 1'b0;
      re_out_q   <= '0;
      im_out_q   <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      log2len_q  <= log2len_d;
      fft_done_q <= fft_done_i;
      overrun_q  <= overrun_d;
      re_out_q   <= re_out_d;
      im_out_q   <= im_out_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
    end
  end

  assign m_if.valid = (state_q == StStream);
  assign m_if.re    = re_out_q;
  assign m_if.im    = im_out_q;
  assign m_if.index = idx_q;
  assign m_if.last  = last_q;
  assign busy_o     = (state_q == StStream);
  assign overrun_o  = overrun_q;

endmodule
